// File: rtl/icache_dm.sv
// Direct-mapped, one-word-per-line instruction cache with a single outstanding
// refill on a req/gnt/rvalid bus. Hits are acknowledged combinationally.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | serving hits; a miss latches miss_pc and moves to REQ
// REQ     | o_bus_req high with miss address, waiting for i_bus_gnt
// WAIT    | address accepted, waiting for i_bus_rvalid to fill/bypass
module icache_dm #(
  parameter int INSTR_ADDR_WIDTH = 32,
  parameter int INSTR_WIDTH      = 32,
  parameter int INDEX_WIDTH      = 4
) (
  input  logic                        i_clk,
  input  logic                        i_arst_n,
  input  logic                        i_core_en,
  input  logic                        i_flush,
  input  logic                        i_read_req,
  input  logic [INSTR_ADDR_WIDTH-3:0] i_pc,
  output logic                        o_read_ack,
  output logic [INSTR_WIDTH-1:0]      o_instr,
  output logic                        o_bus_req,
  output logic [INSTR_ADDR_WIDTH-1:0] o_bus_addr,
  input  logic                        i_bus_gnt,
  input  logic                        i_bus_rvalid,
  input  logic [INSTR_WIDTH-1:0]      i_bus_rdata,
  output logic [15:0]                 o_miss_cnt
);

  localparam int PC_WIDTH  = INSTR_ADDR_WIDTH - 2;
  localparam int TAG_WIDTH = PC_WIDTH - INDEX_WIDTH;
  localparam int LINES     = 1 << INDEX_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [LINES-1:0]       valid_q;
  logic [TAG_WIDTH-1:0]   tag_q  [LINES];
  logic [INSTR_WIDTH-1:0] data_q [LINES];

  logic [PC_WIDTH-1:0] miss_pc_q;
  logic                kill_q;
  logic [15:0]         miss_cnt_q;

  logic [INDEX_WIDTH-1:0] req_idx;
  logic [TAG_WIDTH-1:0]   req_tag;
  logic [INDEX_WIDTH-1:0] miss_idx;
  logic [TAG_WIDTH-1:0]   miss_tag;
  logic                   hit;
  logic                   start_miss;
  logic                   fill;

  assign req_idx  = i_pc[INDEX_WIDTH-1:0];
  assign req_tag  = i_pc[PC_WIDTH-1:INDEX_WIDTH];
  assign miss_idx = miss_pc_q[INDEX_WIDTH-1:0];
  assign miss_tag = miss_pc_q[PC_WIDTH-1:INDEX_WIDTH];

  assign hit = i_core_en & i_read_req & valid_q[req_idx] & (tag_q[req_idx] == req_tag);

  always_comb begin
    state_d    = state_q;
    o_read_ack = 1'b0;
    o_instr    = data_q[req_idx];
    o_bus_req  = 1'b0;
    start_miss = 1'b0;
    fill       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        o_read_ack = hit & ~i_flush;
        if (i_core_en & i_read_req & ~hit & ~i_flush) begin
          start_miss = 1'b1;
          state_d    = ST_REQ;
        end
      end
      ST_REQ: begin
        o_bus_req = 1'b1;
        if (i_bus_gnt) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (i_bus_rvalid) begin
          state_d = ST_IDLE;
          // A flush in this cycle or any earlier one of this refill discards the beat.
          if (~kill_q & ~i_flush) begin
            fill = 1'b1;
            if (i_read_req & i_core_en & (i_pc == miss_pc_q)) begin
              o_read_ack = 1'b1;
              o_instr    = i_bus_rdata;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign o_bus_addr = {miss_pc_q, 2'b00};
  assign o_miss_cnt = miss_cnt_q;

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state_q    <= ST_IDLE;
      miss_pc_q  <= '0;
      kill_q     <= 1'b0;
      miss_cnt_q <= '0;
      valid_q    <= '0;
    end else begin
      state_q <= state_d;
      if (start_miss) begin
        miss_pc_q <= i_pc;
        if (miss_cnt_q != 16'hFFFF) begin
          miss_cnt_q <= miss_cnt_q + 16'd1;
        end
      end
      if (state_d == ST_IDLE) begin
        kill_q <= 1'b0;
      end else if (i_flush && state_q != ST_IDLE) begin
        kill_q <= 1'b1;
      end
      if (i_flush) begin
        valid_q <= '0;
      end else if (fill) begin
        valid_q[miss_idx] <= 1'b1;
      end
    end
  end

  // Tag and data arrays carry no reset; valid bits gate every use.
  always_ff @(posedge i_clk) begin
    if (fill) begin
      tag_q[miss_idx]  <= miss_tag;
      data_q[miss_idx] <= i_bus_rdata;
    end
  end

endmodule

// File: tb/tb_icache_dm.sv
// Directed bench for icache_dm: miss/refill/bypass, conflicts, request change,
// flush interactions, core disable, reset mid-refill and counter saturation.
module tb_icache_dm;

  logic        i_clk = 1'b0;
  logic        i_arst_n;
  logic        i_core_en;
  logic        i_flush;
  logic        i_read_req;
  logic [29:0] i_pc;
  logic        o_read_ack;
  logic [31:0] o_instr;
  logic        o_bus_req;
  logic [31:0] o_bus_addr;
  logic        i_bus_gnt;
  logic        i_bus_rvalid;
  logic [31:0] i_bus_rdata;
  logic [15:0] o_miss_cnt;

  int n_checks = 0;
  int n_errors = 0;

  icache_dm dut (
    .i_clk        (i_clk),
    .i_arst_n     (i_arst_n),
    .i_core_en    (i_core_en),
    .i_flush      (i_flush),
    .i_read_req   (i_read_req),
    .i_pc         (i_pc),
    .o_read_ack   (o_read_ack),
    .o_instr      (o_instr),
    .o_bus_req    (o_bus_req),
    .o_bus_addr   (o_bus_addr),
    .i_bus_gnt    (i_bus_gnt),
    .i_bus_rvalid (i_bus_rvalid),
    .i_bus_rdata  (i_bus_rdata),
    .o_miss_cnt   (o_miss_cnt)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic grant();
    i_bus_gnt = 1'b1;
    tick();
    i_bus_gnt = 1'b0;
  endtask

  initial begin
    i_arst_n = 1'b0; i_core_en = 1'b1; i_flush = 1'b0; i_read_req = 1'b0;
    i_pc = '0; i_bus_gnt = 1'b0; i_bus_rvalid = 1'b0; i_bus_rdata = '0;
    #3;
    chk("rst_ack", {31'd0, o_read_ack}, 32'd0);
    chk("rst_bus_req", {31'd0, o_bus_req}, 32'd0);
    chk("rst_bus_addr", o_bus_addr, 32'd0);
    chk("rst_miss_cnt", {16'd0, o_miss_cnt}, 32'd0);
    tick();
    i_arst_n = 1'b1;
    tick();

    // First miss: pc 0x10, grant after 2 cycles, rvalid 3 cycles later
    i_read_req = 1'b1; i_pc = 30'h10; #1;
    chk("m1_ack", {31'd0, o_read_ack}, 32'd0);
    tick();
    chk("m1_cnt", {16'd0, o_miss_cnt}, 32'd1);
    chk("m1_bus_req", {31'd0, o_bus_req}, 32'd1);
    chk("m1_bus_addr", o_bus_addr, 32'h40);
    chk("m1_ack_req", {31'd0, o_read_ack}, 32'd0);
    tick();
    chk("m1_bus_req_hold", {31'd0, o_bus_req}, 32'd1);
    chk("m1_bus_addr_hold", o_bus_addr, 32'h40);
    grant();
    chk("m1_bus_req_wait", {31'd0, o_bus_req}, 32'd0);
    tick(); tick();
    i_bus_rvalid = 1'b1; i_bus_rdata = 32'h2408000A; #1;
    chk("m1_bypass_ack", {31'd0, o_read_ack}, 32'd1);
    chk("m1_bypass_instr", o_instr, 32'h2408000A);
    tick();
    i_bus_rvalid = 1'b0; i_bus_rdata = 32'hDEADBEEF; #1;

    // Repeat: hit in same cycle
    chk("h1_ack", {31'd0, o_read_ack}, 32'd1);
    chk("h1_instr", o_instr, 32'h2408000A);
    tick();
    chk("h1_no_bus_req", {31'd0, o_bus_req}, 32'd0);
    chk("h1_cnt", {16'd0, o_miss_cnt}, 32'd1);

    // Conflict eviction on index 0
    i_pc = 30'h20; #1;
    chk("c1_ack", {31'd0, o_read_ack}, 32'd0);
    tick();
    chk("c1_cnt", {16'd0, o_miss_cnt}, 32'd2);
    chk("c1_bus_addr", o_bus_addr, 32'h80);
    grant();
    i_bus_rvalid = 1'b1; i_bus_rdata = 32'hAAAA0020; #1;
    chk("c1_bypass", o_instr, 32'hAAAA0020);
    tick();
    i_bus_rvalid = 1'b0;
    i_pc = 30'h10; #1;
    chk("c2_evicted", {31'd0, o_read_ack}, 32'd0);
    tick();
    chk("c2_cnt", {16'd0, o_miss_cnt}, 32'd3);
    grant();
    i_bus_rvalid = 1'b1; i_bus_rdata = 32'h2408000A;
    tick();
    i_bus_rvalid = 1'b0; #1;
    chk("c2_hit", {31'd0, o_read_ack}, 32'd1);

    // Request moves to 0x33 during WAIT of 0x11
    i_pc = 30'h11; #1;
    tick();
    chk("r1_cnt", {16'd0, o_miss_cnt}, 32'd4);
    grant();
    i_pc = 30'h33; i_bus_rvalid = 1'b1; i_bus_rdata = 32'h11111111; #1;
    chk("r1_no_bypass", {31'd0, o_read_ack}, 32'd0);
    tick();
    i_bus_rvalid = 1'b0; #1;
    chk("r1_33_miss", {31'd0, o_read_ack}, 32'd0);
    tick();
    chk("r1_33_cnt", {16'd0, o_miss_cnt}, 32'd5);
    chk("r1_33_addr", o_bus_addr, 32'hCC);
    grant();
    i_bus_rvalid = 1'b1; i_bus_rdata = 32'h33333333; #1;
    chk("r1_33_bypass_ack", {31'd0, o_read_ack}, 32'd1);
    chk("r1_33_bypass_instr", o_instr, 32'h33333333);
    tick();
    i_bus_rvalid = 1'b0;
    i_pc = 30'h11; #1;
    chk("r1_11_hit", {31'd0, o_read_ack}, 32'd1);
    chk("r1_11_instr", o_instr, 32'h11111111);

    // Flush during WAIT kills the refill
    i_pc = 30'h25; #1;
    tick();
    chk("f1_cnt", {16'd0, o_miss_cnt}, 32'd6);
    grant();
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    i_bus_rvalid = 1'b1; i_bus_rdata = 32'h55555555; #1;
    chk("f1_killed_ack", {31'd0, o_read_ack}, 32'd0);
    tick();
    i_bus_rvalid = 1'b0; #1;
    chk("f1_remiss", {31'd0, o_read_ack}, 32'd0);
    tick();
    chk("f1_cnt2", {16'd0, o_miss_cnt}, 32'd7);
    grant();
    i_bus_rvalid = 1'b1; i_bus_rdata = 32'h25252525; #1;
    chk("f1_bypass", o_instr, 32'h25252525);
    tick();
    i_bus_rvalid = 1'b0;

    // 0x11 was invalidated by the flush; refill it, then flush in IDLE
    i_pc = 30'h11; #1;
    chk("f2_11_miss", {31'd0, o_read_ack}, 32'd0);
    tick();
    grant();
    i_bus_rvalid = 1'b1; i_bus_rdata = 32'h11111111;
    tick();
    i_bus_rvalid = 1'b0; #1;
    chk("f2_11_hit", {31'd0, o_read_ack}, 32'd1);
    i_pc = 30'h25; #1;
    chk("f2_25_hit", {31'd0, o_read_ack}, 32'd1);
    i_flush = 1'b1; #1;
    chk("f2_flush_cycle_ack", {31'd0, o_read_ack}, 32'd0);
    tick();
    i_flush = 1'b0; #1;
    chk("f2_25_after_flush", {31'd0, o_read_ack}, 32'd0);
    i_pc = 30'h11; #1;
    chk("f2_11_after_flush", {31'd0, o_read_ack}, 32'd0);
    i_read_req = 1'b0; #1;
    tick();
    chk("f2_cnt", {16'd0, o_miss_cnt}, 32'd8);

    // Core disabled: no ack, no miss
    i_core_en = 1'b0; i_read_req = 1'b1; i_pc = 30'h40; #1;
    chk("ce_ack", {31'd0, o_read_ack}, 32'd0);
    tick();
    chk("ce_bus_req", {31'd0, o_bus_req}, 32'd0);
    chk("ce_cnt", {16'd0, o_miss_cnt}, 32'd8);
    i_core_en = 1'b1;

    // Flush coincident with refill write: line stays invalid
    i_pc = 30'h26; #1;
    tick();
    chk("fr_cnt", {16'd0, o_miss_cnt}, 32'd9);
    grant();
    i_bus_rvalid = 1'b1; i_bus_rdata = 32'h26262626; i_flush = 1'b1; #1;
    chk("fr_ack", {31'd0, o_read_ack}, 32'd0);
    tick();
    i_bus_rvalid = 1'b0; i_flush = 1'b0; #1;
    chk("fr_line_invalid", {31'd0, o_read_ack}, 32'd0);
    i_read_req = 1'b0; #1;

    // Reset mid-refill
    i_read_req = 1'b1; i_pc = 30'h27; #1;
    tick();
    grant();
    i_read_req = 1'b0;
    i_arst_n = 1'b0; #1;
    chk("rr_bus_req", {31'd0, o_bus_req}, 32'd0);
    chk("rr_bus_addr", o_bus_addr, 32'd0);
    chk("rr_cnt", {16'd0, o_miss_cnt}, 32'd0);
    tick();
    i_arst_n = 1'b1;
    i_bus_rvalid = 1'b1; i_bus_rdata = 32'h27272727;
    tick();
    i_bus_rvalid = 1'b0;
    chk("rr_idle", {31'd0, o_bus_req}, 32'd0);
    i_read_req = 1'b1; #1;
    chk("rr_late_rvalid_ignored", {31'd0, o_read_ack}, 32'd0);
    i_read_req = 1'b0; #1;

    // Saturation: preload counter near the top, then two misses
    force dut.miss_cnt_q = 16'hFFFE;
    #1;
    release dut.miss_cnt_q;
    #1;
    chk("sat_preload", {16'd0, o_miss_cnt}, 32'hFFFE);
    i_read_req = 1'b1; i_pc = 30'h30; #1;
    tick();
    chk("sat_ffff", {16'd0, o_miss_cnt}, 32'hFFFF);
    grant();
    i_bus_rvalid = 1'b1; i_bus_rdata = 32'h30303030;
    tick();
    i_bus_rvalid = 1'b0;
    i_pc = 30'h31; #1;
    tick();
    chk("sat_hold", {16'd0, o_miss_cnt}, 32'hFFFF);
    grant();
    i_bus_rvalid = 1'b1; i_bus_rdata = 32'h31313131;
    tick();
    i_bus_rvalid = 1'b0; i_read_req = 1'b0;
    tick();
    chk("sat_hold2", {16'd0, o_miss_cnt}, 32'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
